bm_req_arbiter: RTL and testbench

- Shares the single bus-master (BM) request port of the PCIe-to-IB bridge among N_REQ local requesters, e.g. DMA channels.
- Uses round-robin arbitration and registered request forwarding.
- Rewrites the top tag bits with the requester index so completions route back to the right requester.
- Tracks outstanding operations per requester and throttles each one at MAX_OUT.
- Sits between the DMA engines and the bridge's BM_* ports.

---
 rtl/bm_req_arbiter_pkg.sv | 25 ++
 rtl/bm_rr_arbiter.sv | 37 +++
 rtl/bm_req_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_bm_req_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bm_req_arbiter_pkg.sv
// Shared types and constants for the bus-master request arbiter.
// Holds the FSM state enum, the BM field widths and a constant clog2 helper.
package bm_req_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam int GADDR_W   = 64;
  localparam int LADDR_W   = 32;
  localparam int LEN_W     = 12;
  localparam int TTYPE_W   = 2;
  localparam int DEF_TAG_W = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bm_rr_arbiter.sv
// Combinational round-robin picker: first eligible index strictly after the pointer, wrapping.
// The pointer register lives in the parent; this block only rotates priority.
module bm_rr_arbiter
  import bm_req_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Indices above the pointer win first; the second pass handles the wrap-around.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid_o && eligible_i[i] && (i > int'(ptr_i))) begin
        valid_o    = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid_o && eligible_i[i] && (i <= int'(ptr_i))) begin
        valid_o    = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/bm_req_arbiter.sv
// Shares the bridge's single BM request port among N_REQ requesters with round-robin grants,
// tag-based completion routing and a per-requester cap on outstanding operations.
module bm_req_arbiter
  import bm_req_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = clog2(N_REQ),
  parameter int TAG_W   = DEF_TAG_W,
  parameter int MAX_OUT = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [N_REQ*GADDR_W-1:0]   RQ_GLOBAL_ADDR,
  input  logic [N_REQ*LADDR_W-1:0]   RQ_LOCAL_ADDR,
  input  logic [N_REQ*LEN_W-1:0]     RQ_LENGTH,
  input  logic [N_REQ*TAG_W-1:0]     RQ_TAG,
  input  logic [N_REQ*TTYPE_W-1:0]   RQ_TRANS_TYPE,
  input  logic [N_REQ-1:0]           RQ_REQ,
  output logic [N_REQ-1:0]           RQ_ACK,
  output logic [N_REQ-1:0]           RQ_OP_DONE,
  output logic [TAG_W-1:0]           RQ_OP_TAG,
  output logic [GADDR_W-1:0]         BM_GLOBAL_ADDR,
  output logic [LADDR_W-1:0]         BM_LOCAL_ADDR,
  output logic [LEN_W-1:0]           BM_LENGTH,
  output logic [TAG_W-1:0]           BM_TAG,
  output logic [TTYPE_W-1:0]         BM_TRANS_TYPE,
  output logic                       BM_REQ,
  input  logic                       BM_ACK,
  input  logic [TAG_W-1:0]           BM_OP_TAG,
  input  logic                       BM_OP_DONE,
  output logic                       ERR_TAG
);

  localparam int CNT_W = clog2(MAX_OUT + 1);
  localparam int LOW_W = TAG_W - IDX_W;

  state_e               state_q;
  logic                 bmReq_q;
  logic [IDX_W-1:0]     gnt_q;
  logic [N_REQ-1:0]     gntOh_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [CNT_W-1:0]     cnt_q [N_REQ];
  logic [GADDR_W-1:0]   bmGlobalAddr_q, bmGlobalAddr_d;
  logic [LADDR_W-1:0]   bmLocalAddr_q, bmLocalAddr_d;
  logic [LEN_W-1:0]     bmLength_q, bmLength_d;
  logic [TTYPE_W-1:0]   bmTransType_q, bmTransType_d;
  logic [LOW_W-1:0]     tagLow_d;
  logic [TAG_W-1:0]     bmTag_q;
  logic [N_REQ-1:0]     rqOpDone_q;
  logic [TAG_W-1:0]     rqOpTag_q;
  logic                 errTag_q;

  logic [N_REQ-1:0]     eligible;
  logic [N_REQ-1:0]     arbGrant;
  logic [IDX_W-1:0]     arbIdx;
  logic                 arbValid;
  logic                 ackFire;
  logic [IDX_W-1:0]     doneIdx;
  logic [N_REQ-1:0]     doneHit;
  logic [N_REQ-1:0]     incHit;
  logic                 unusedTagBits;

  assign ackFire = (state_q == REQ) && bmReq_q && BM_ACK;
  assign doneIdx = BM_OP_TAG[TAG_W-1 -: IDX_W];

  // A requester at its cap stays out of arbitration until a completion frees a slot.
  always_comb begin
    eligible = '0;
    incHit   = '0;
    doneHit  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = RQ_REQ[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
      incHit[i]   = ackFire && gntOh_q[i];
      doneHit[i]  = BM_OP_DONE && (doneIdx == IDX_W'(i)) && (cnt_q[i] != '0);
    end
  end

  bm_rr_arbiter #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) uArb (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (arbGrant),
    .idx_o      (arbIdx),
    .valid_o    (arbValid)
  );

  // One-hot AND-OR select of the winning requester's fields.
  always_comb begin
    bmGlobalAddr_d = '0;
    bmLocalAddr_d  = '0;
    bmLength_d     = '0;
    bmTransType_d  = '0;
    tagLow_d       = '0;
    unusedTagBits  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      unusedTagBits = unusedTagBits ^ (^RQ_TAG[i*TAG_W+LOW_W +: IDX_W]);
      if (arbGrant[i]) begin
        bmGlobalAddr_d = RQ_GLOBAL_ADDR[i*GADDR_W +: GADDR_W];
        bmLocalAddr_d  = RQ_LOCAL_ADDR[i*LADDR_W +: LADDR_W];
        bmLength_d     = RQ_LENGTH[i*LEN_W +: LEN_W];
        bmTransType_d  = RQ_TRANS_TYPE[i*TTYPE_W +: TTYPE_W];
        tagLow_d       = RQ_TAG[i*TAG_W +: LOW_W];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= IDLE;
      bmReq_q        <= 1'b0;
      gnt_q          <= '0;
      gntOh_q        <= '0;
      ptr_q          <= IDX_W'(N_REQ - 1);
      bmGlobalAddr_q <= '0;
      bmLocalAddr_q  <= '0;
      bmLength_q     <= '0;
      bmTransType_q  <= '0;
      bmTag_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arbValid) begin
            bmGlobalAddr_q <= bmGlobalAddr_d;
            bmLocalAddr_q  <= bmLocalAddr_d;
            bmLength_q     <= bmLength_d;
            bmTransType_q  <= bmTransType_d;
            bmTag_q        <= {arbIdx, tagLow_d};
            bmReq_q        <= 1'b1;
            gnt_q          <= arbIdx;
            gntOh_q        <= arbGrant;
            state_q        <= REQ;
          end
        end
        REQ: begin
          if (ackFire) begin
            bmReq_q <= 1'b0;
            ptr_q   <= gnt_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Same-cycle accept and completion on one counter cancel out.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      rqOpDone_q <= '0;
      rqOpTag_q  <= '0;
      errTag_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        case ({incHit[i], doneHit[i]})
          2'b10: if (cnt_q[i] != CNT_W'(MAX_OUT)) cnt_q[i] <= cnt_q[i] + 1'b1;
          2'b01: cnt_q[i] <= cnt_q[i] - 1'b1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
      rqOpDone_q <= doneHit;
      if (|doneHit) begin
        rqOpTag_q <= {{IDX_W{1'b0}}, BM_OP_TAG[LOW_W-1:0]};
      end
      errTag_q <= BM_OP_DONE && !(|doneHit);
    end
  end

  assign RQ_ACK         = ackFire ? gntOh_q : '0;
  assign RQ_OP_DONE     = rqOpDone_q;
  assign RQ_OP_TAG      = rqOpTag_q;
  assign BM_GLOBAL_ADDR = bmGlobalAddr_q;
  assign BM_LOCAL_ADDR  = bmLocalAddr_q;
  assign BM_LENGTH      = bmLength_q;
  assign BM_TAG         = bmTag_q;
  assign BM_TRANS_TYPE  = bmTransType_q;
  assign BM_REQ         = bmReq_q;
  assign ERR_TAG        = errTag_q;

endmodule

// File: tb/tb_bm_req_arbiter.sv
// Directed bench for bm_req_arbiter: grant order, tag rewrite, throttling, completion routing,
// error pulses and asynchronous reset, with a second three-requester instance for the invalid-index case.
module tb_bm_req_arbiter;

  logic          CLK;
  logic          RESET;
  logic [255:0]  rqGlobalAddr;
  logic [127:0]  rqLocalAddr;
  logic [47:0]   rqLength;
  logic [63:0]   rqTag;
  logic [7:0]    rqTransType;
  logic [3:0]    rqReq;
  logic [3:0]    rqAck;
  logic [3:0]    rqOpDone;
  logic [15:0]   rqOpTag;
  logic [63:0]   bmGlobalAddr;
  logic [31:0]   bmLocalAddr;
  logic [11:0]   bmLength;
  logic [15:0]   bmTag;
  logic [1:0]    bmTransType;
  logic          bmReq;
  logic          bmAck;
  logic [15:0]   bmOpTag;
  logic          bmOpDone;
  logic          errTag;

  logic [191:0]  g3;
  logic [95:0]   l3;
  logic [35:0]   len3;
  logic [47:0]   tag3;
  logic [5:0]    tt3;
  logic [2:0]    req3;
  logic [2:0]    ack3;
  logic [2:0]    opDone3;
  logic [15:0]   opTag3;
  logic [63:0]   bmG3;
  logic [31:0]   bmL3;
  logic [11:0]   bmLen3;
  logic [15:0]   bmTag3;
  logic [1:0]    bmTt3;
  logic          bmReq3;
  logic [15:0]   doneTag3;
  logic          done3;
  logic          err3;

  int checkCount;
  int errorCount;
  int protocolViolations;

  bm_req_arbiter #(.N_REQ(4), .TAG_W(16), .MAX_OUT(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .RQ_GLOBAL_ADDR(rqGlobalAddr), .RQ_LOCAL_ADDR(rqLocalAddr), .RQ_LENGTH(rqLength),
    .RQ_TAG(rqTag), .RQ_TRANS_TYPE(rqTransType), .RQ_REQ(rqReq), .RQ_ACK(rqAck),
    .RQ_OP_DONE(rqOpDone), .RQ_OP_TAG(rqOpTag),
    .BM_GLOBAL_ADDR(bmGlobalAddr), .BM_LOCAL_ADDR(bmLocalAddr), .BM_LENGTH(bmLength),
    .BM_TAG(bmTag), .BM_TRANS_TYPE(bmTransType), .BM_REQ(bmReq), .BM_ACK(bmAck),
    .BM_OP_TAG(bmOpTag), .BM_OP_DONE(bmOpDone), .ERR_TAG(errTag)
  );

  bm_req_arbiter #(.N_REQ(3), .TAG_W(16), .MAX_OUT(8)) dut3 (
    .CLK(CLK), .RESET(RESET),
    .RQ_GLOBAL_ADDR(g3), .RQ_LOCAL_ADDR(l3), .RQ_LENGTH(len3),
    .RQ_TAG(tag3), .RQ_TRANS_TYPE(tt3), .RQ_REQ(req3), .RQ_ACK(ack3),
    .RQ_OP_DONE(opDone3), .RQ_OP_TAG(opTag3),
    .BM_GLOBAL_ADDR(bmG3), .BM_LOCAL_ADDR(bmL3), .BM_LENGTH(bmLen3),
    .BM_TAG(bmTag3), .BM_TRANS_TYPE(bmTt3), .BM_REQ(bmReq3), .BM_ACK(1'b0),
    .BM_OP_TAG(doneTag3), .BM_OP_DONE(done3), .ERR_TAG(err3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] gAddrOf(input int i);
    return 64'h0123_4567_89AB_0000 + 64'(i * 17);
  endfunction

  function automatic logic [31:0] lAddrOf(input int i);
    return 32'h8000_0000 + 32'(i * 4096);
  endfunction

  function automatic logic [15:0] rqTagOf(input int i);
    case (i)
      0:       return 16'hC0A0;
      1:       return 16'h8111;
      2:       return 16'h0123;
      default: return 16'h3F33;
    endcase
  endfunction

  function automatic logic [15:0] expTagOf(input int i);
    case (i)
      0:       return 16'h00A0;
      1:       return 16'h4111;
      2:       return 16'h8123;
      default: return 16'hFF33;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyReset();
    RESET    = 1'b1;
    rqReq    = '0;
    bmAck    = 1'b0;
    bmOpDone = 1'b0;
    bmOpTag  = '0;
    step();
    step();
    RESET = 1'b0;
  endtask

  // A latched request whose owner drops RQ_REQ before its accept is a protocol violation.
  always @(posedge CLK) begin
    if (!RESET && bmReq && !rqAck[bmTag[15:14]] && !rqReq[bmTag[15:14]]) begin
      protocolViolations++;
      $display("[TB] protocol violation: requester %0d withdrew a latched request", bmTag[15:14]);
    end
  end

  initial begin : applyStimulus
    int lat;
    int acks1;
    int acks3;
    int order;
    bit seen;
    checkCount = 0;
    errorCount = 0;
    protocolViolations = 0;
    for (int i = 0; i < 4; i++) begin
      rqGlobalAddr[i*64 +: 64] = gAddrOf(i);
      rqLocalAddr[i*32 +: 32]  = lAddrOf(i);
      rqLength[i*12 +: 12]     = 12'(100 + i);
      rqTag[i*16 +: 16]        = rqTagOf(i);
      rqTransType[i*2 +: 2]    = 2'(i);
    end
    g3 = '0; l3 = '0; len3 = '0; tag3 = '0; tt3 = '0; req3 = '0;
    done3 = 1'b0; doneTag3 = '0;

    RESET = 1'b1;
    rqReq = '0; bmAck = 1'b0; bmOpDone = 1'b0; bmOpTag = '0;
    step();
    step();
    checkOutput("rstBmReq", 64'(bmReq), 64'd0);
    checkOutput("rstRqAck", 64'(rqAck), 64'd0);
    checkOutput("rstOpDone", 64'(rqOpDone), 64'd0);
    checkOutput("rstErrTag", 64'(errTag), 64'd0);
    checkOutput("rstBmTag", 64'(bmTag), 64'd0);
    checkOutput("rstGAddr", bmGlobalAddr, 64'd0);
    RESET = 1'b0;

    // Single requester 2, accepted three cycles after BM_REQ rises.
    rqReq = 4'b0100;
    seen = 1'b0;
    lat = 0;
    for (int n = 1; n <= 8 && !seen; n++) begin
      step();
      settle();
      if (bmReq) begin
        seen = 1'b1;
        lat = n;
      end
    end
    checkOutput("bmReqLatency", 64'(lat), 64'd1);
    checkOutput("singleTag", 64'(bmTag), 64'h8123);
    checkOutput("singleGAddr", bmGlobalAddr, gAddrOf(2));
    checkOutput("singleLAddr", 64'(bmLocalAddr), 64'(lAddrOf(2)));
    checkOutput("singleLen", 64'(bmLength), 64'd102);
    checkOutput("singleTType", 64'(bmTransType), 64'd2);
    step(); settle();
    checkOutput("singleHold1", 64'(bmReq), 64'd1);
    checkOutput("singleNoAck", 64'(rqAck), 64'd0);
    step(); settle();
    checkOutput("singleHoldTag", 64'(bmTag), 64'h8123);
    step();
    bmAck = 1'b1;
    settle();
    checkOutput("singleAck", 64'(rqAck), 64'h4);
    step();
    bmAck = 1'b0;
    rqReq = '0;
    settle();
    checkOutput("singleReqDrop", 64'(bmReq), 64'd0);
    checkOutput("singleAckGone", 64'(rqAck), 64'd0);

    // All four requesting with BM_ACK tied high: grants 0,1,2,3,0,1 on every other cycle.
    applyReset();
    rqReq = 4'hF;
    bmAck = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 12) begin
        rqReq = '0;
        bmAck = 1'b0;
      end
      settle();
      checkOutput($sformatf("rrReq%0d", k), 64'(bmReq), 64'(k % 2));
      if (k % 2 == 1) begin
        order = ((k - 1) / 2) % 4;
        checkOutput($sformatf("rrTag%0d", k), 64'(bmTag), 64'(expTagOf(order)));
        checkOutput($sformatf("rrAck%0d", k), 64'(rqAck), 64'(4'b0001 << order));
      end else begin
        checkOutput($sformatf("rrAck%0d", k), 64'(rqAck), 64'd0);
      end
    end

    // Throttle: requester 1 fills its eight slots, then only requester 3 is served.
    applyReset();
    rqReq = 4'b0010;
    bmAck = 1'b1;
    acks1 = 0;
    for (int k = 1; k <= 16; k++) begin
      step(); settle();
      if (rqAck[1]) acks1++;
    end
    checkOutput("throttleFill", 64'(acks1), 64'd8);
    rqReq = 4'b1010;
    acks1 = 0;
    acks3 = 0;
    for (int k = 1; k <= 6; k++) begin
      step(); settle();
      if (rqAck[1]) acks1++;
      if (rqAck[3]) acks3++;
    end
    checkOutput("throttleBlocked1", 64'(acks1), 64'd0);
    checkOutput("throttleServed3", 64'(acks3), 64'd3);
    bmAck = 1'b0;
    rqReq = 4'b0010;
    bmOpDone = 1'b1;
    bmOpTag = 16'h4005;
    step();
    bmOpDone = 1'b0;
    settle();
    checkOutput("doneRoute", 64'(rqOpDone), 64'h2);
    checkOutput("doneTag", 64'(rqOpTag), 64'h0005);
    checkOutput("doneNoErr", 64'(errTag), 64'd0);
    checkOutput("doneNotYetGranted", 64'(bmReq), 64'd0);
    step(); settle();
    checkOutput("regrantReq", 64'(bmReq), 64'd1);
    checkOutput("regrantTag", 64'(bmTag), 64'h4111);
    checkOutput("donePulseEnd", 64'(rqOpDone), 64'd0);

    // Accept and completion on requester 1 in the same cycle leave its count at seven.
    bmAck = 1'b1;
    bmOpDone = 1'b1;
    bmOpTag = 16'h4006;
    settle();
    checkOutput("simulAck", 64'(rqAck), 64'h2);
    step();
    bmOpDone = 1'b0;
    settle();
    checkOutput("simulDone", 64'(rqOpDone), 64'h2);
    checkOutput("simulDoneTag", 64'(rqOpTag), 64'h0006);
    step(); settle();
    checkOutput("simulStillEligible", 64'(bmReq), 64'd1);
    checkOutput("simulAck2", 64'(rqAck), 64'h2);
    step(); settle();
    checkOutput("atMaxIdle", 64'(bmReq), 64'd0);
    step(); settle();
    checkOutput("atMaxBlocked", 64'(bmReq), 64'd0);
    bmAck = 1'b0;
    rqReq = '0;

    // Completions for an idle counter and for a nonexistent requester.
    bmOpDone = 1'b1;
    bmOpTag = 16'h0001;
    done3 = 1'b1;
    doneTag3 = 16'hC001;
    step();
    bmOpDone = 1'b0;
    done3 = 1'b0;
    settle();
    checkOutput("underflowErr", 64'(errTag), 64'd1);
    checkOutput("underflowNoDone", 64'(rqOpDone), 64'd0);
    checkOutput("badIdxErr", 64'(err3), 64'd1);
    checkOutput("badIdxNoDone", 64'(opDone3), 64'd0);
    step(); settle();
    checkOutput("errPulseEnd", 64'(errTag), 64'd0);

    // Asynchronous reset while a request is pending.
    rqReq = 4'b0100;
    step(); settle();
    checkOutput("preResetReq", 64'(bmReq), 64'd1);
    RESET = 1'b1;
    #1;
    checkOutput("asyncResetDrop", 64'(bmReq), 64'd0);
    rqReq = 4'b1001;
    step();
    step();
    RESET = 1'b0;
    settle();
    checkOutput("postResetIdle", 64'(bmReq), 64'd0);
    step(); settle();
    checkOutput("postResetReq", 64'(bmReq), 64'd1);
    checkOutput("postResetWinner", 64'(bmTag), 64'h00A0);
    bmAck = 1'b1;
    settle();
    checkOutput("postResetAck0", 64'(rqAck), 64'h1);
    step();
    step(); settle();
    checkOutput("postResetNext3", 64'(bmTag), 64'hFF33);
    checkOutput("postResetAck3", 64'(rqAck), 64'h8);
    step();
    rqReq = 4'b0010;
    bmAck = 1'b0;
    step(); settle();
    checkOutput("cntClearedReq", 64'(bmReq), 64'd1);
    checkOutput("cntClearedTag", 64'(bmTag), 64'h4111);
    bmAck = 1'b1;
    step();
    rqReq = '0;
    bmAck = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
